// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the parametrised vending controller:
//   - state_t      : controller FSM states (IDLE / CHANGE / ADMIN)
//   - idx_w()      : index width for an N-entry selector (at least 1 bit)
//   - lsb_index()  : position of the lowest set bit. The item_sel and coin_in
//                    paths both use it, so a multi-bit press resolves to the
//                    lowest index. Vectors of up to 32 bits are supported.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHANGE = 2'd1,
    ST_ADMIN  = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lsb_index(input logic [31:0] v);
    int idx;
    idx = 0;
    // Scan downwards so that the last hit is the lowest set bit.
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/vending_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// vending_ctrl_param_if
// Groups the controller's button, hopper and status signals.
//   master : the environment. It drives coin_in, item_sel, cancel, admin_mode
//            and change_ready.
//   slave  : the controller. It drives credit, the vend, change and error
//            outputs, sold_out and busy.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface vending_ctrl_param_if
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS = 8,
  parameter int NUM_COINS = 3,
  parameter int CREDIT_W  = 8
);
  localparam int ITEM_IDX_W = idx_w(NUM_ITEMS);
  localparam int COIN_IDX_W = idx_w(NUM_COINS);

  logic [NUM_COINS-1:0]  coin_in;
  logic [NUM_ITEMS-1:0]  item_sel;
  logic                  cancel;
  logic                  admin_mode;
  logic                  change_ready;
  logic [CREDIT_W-1:0]   credit;
  logic                  vend_valid;
  logic [ITEM_IDX_W-1:0] vend_item;
  logic                  change_valid;
  logic [COIN_IDX_W-1:0] change_coin;
  logic                  coin_reject;
  logic                  err_sold_out;
  logic                  err_funds;
  logic [NUM_ITEMS-1:0]  sold_out;
  logic                  busy;

  modport master (
    output coin_in, item_sel, cancel, admin_mode, change_ready,
    input  credit, vend_valid, vend_item, change_valid, change_coin,
           coin_reject, err_sold_out, err_funds, sold_out, busy
  );

  modport slave (
    input  coin_in, item_sel, cancel, admin_mode, change_ready,
    output credit, vend_valid, vend_item, change_valid, change_coin,
           coin_reject, err_sold_out, err_funds, sold_out, busy
  );
endinterface

// File: rtl/change_picker.sv
// ---------------------------------------------------------------------------
// change_picker
// This block is combinational. It finds the largest coin denomination that
// does not exceed credit_i. Denomination values must strictly increase with
// their index, so the highest index that fits is the greedy choice.
//   credit_i   : credit to be returned
//   found_o    : at least one denomination fits
//   coin_idx_o : index of the largest fitting denomination (0 when none fits)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module change_picker
  import vending_pkg::*;
#(
  parameter int                            NUM_COINS   = 3,
  parameter int                            CREDIT_W    = 8,
  parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = {8'd10, 8'd5, 8'd1}
)(
  input  logic [CREDIT_W-1:0]           credit_i,
  output logic                          found_o,
  output logic [idx_w(NUM_COINS)-1:0]   coin_idx_o
);
  localparam int COIN_IDX_W = idx_w(NUM_COINS);

  always_comb begin
    // NOTE: outputs get a default before the loop so no path leaves them unassigned (no latch).
    found_o    = 1'b0;
    coin_idx_o = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (COIN_VALUES[i*CREDIT_W +: CREDIT_W] <= credit_i) begin
        found_o    = 1'b1;
        coin_idx_o = COIN_IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/vending_ctrl_param.sv
// ---------------------------------------------------------------------------
// vending_ctrl_param
// This is the parametrised vending-machine control core. It provides:
//   - saturating credit
//   - per-item stock counters
//   - sold-out and insufficient-funds error pulses
//   - greedy change return, one coin at a time, with a hopper handshake
//   - an admin mode for restocking items and clearing the cash box
// All outputs come from flops or from direct decodes of flops.
//   clk : system clock
//   rst : asynchronous, active-low reset
//   bus : vending_ctrl_param_if.slave. It carries the button inputs, the
//         hopper handshake, credit, the vend/change/error pulses, sold_out
//         and busy.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vending_ctrl_param
  import vending_pkg::*;
#(
  parameter int                            NUM_ITEMS   = 8,
  parameter int                            NUM_COINS   = 3,
  parameter int                            CREDIT_W    = 8,
  parameter int                            STOCK_W     = 4,
  parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = {8'd10, 8'd5, 8'd1},
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICES =
    {8'd25, 8'd20, 8'd15, 8'd10, 8'd7, 8'd12, 8'd5, 8'd2}
)(
  input  logic                   clk,
  input  logic                   rst,
  vending_ctrl_param_if.slave    bus
);
  localparam int ITEM_IDX_W = idx_w(NUM_ITEMS);
  localparam int COIN_IDX_W = idx_w(NUM_COINS);
  localparam logic [STOCK_W-1:0] MAX_STOCK = '1;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [COIN_IDX_W-1:0] idx);
    return COIN_VALUES[int'(idx)*CREDIT_W +: CREDIT_W];
  endfunction

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [STOCK_W-1:0]    stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]    stock_d [NUM_ITEMS];
  logic                  vend_valid_q, vend_valid_d;
  logic [ITEM_IDX_W-1:0] vend_item_q, vend_item_d;
  logic                  change_valid_q, change_valid_d;
  logic [COIN_IDX_W-1:0] change_coin_q, change_coin_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  err_sold_out_q, err_sold_out_d;
  logic                  err_funds_q, err_funds_d;

  // Input decode. Multi-bit presses resolve to the lowest set index.
  logic                  item_hit, coin_hit, coin_multi, accept;
  logic [ITEM_IDX_W-1:0] item_idx;
  logic [COIN_IDX_W-1:0] coin_idx;
  logic [CREDIT_W-1:0]   price;
  logic [CREDIT_W:0]     coin_sum;
  logic [CREDIT_W-1:0]   pick_credit;
  logic                  pick_found;
  logic [COIN_IDX_W-1:0] pick_idx;

  assign item_hit   = |bus.item_sel;
  assign coin_hit   = |bus.coin_in;
  assign coin_multi = (bus.coin_in & (bus.coin_in - 1'b1)) != '0;
  assign item_idx   = ITEM_IDX_W'(lsb_index(32'(bus.item_sel)));
  assign coin_idx   = COIN_IDX_W'(lsb_index(32'(bus.coin_in)));
  assign price      = ITEM_PRICES[int'(item_idx)*CREDIT_W +: CREDIT_W];
  // One extra bit of headroom, so the carry out flags an overflow past MAX_CREDIT.
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_value(coin_idx)};
  assign accept     = (state_q == ST_CHANGE) && change_valid_q && bus.change_ready;

  // The picker looks at the credit this cycle will leave behind. The coin
  // registered alongside that credit is therefore already the next greedy
  // choice: on a cancel it sees the current credit, and on a hopper accept
  // it sees the credit after the subtraction.
  assign pick_credit = accept ? credit_q - coin_value(change_coin_q) : credit_q;

  change_picker #(
    .NUM_COINS  (NUM_COINS),
    .CREDIT_W   (CREDIT_W),
    .COIN_VALUES(COIN_VALUES)
  ) u_change_picker (
    .credit_i  (pick_credit),
    .found_o   (pick_found),
    .coin_idx_o(pick_idx)
  );

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    vend_valid_d   = 1'b0;
    vend_item_d    = vend_item_q;
    change_valid_d = change_valid_q;
    change_coin_d  = change_coin_q;
    coin_reject_d  = 1'b0;
    err_sold_out_d = 1'b0;
    err_funds_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.admin_mode) begin
          state_d = ST_ADMIN;
        end else if (bus.cancel) begin
          // A credit below the smallest coin cannot be returned, so the cancel is dropped.
          if (pick_found) begin
            state_d        = ST_CHANGE;
            change_valid_d = 1'b1;
            change_coin_d  = pick_idx;
          end
        end else if (item_hit) begin
          if (stock_q[item_idx] == '0) begin
            err_sold_out_d = 1'b1;
          end else if (credit_q < price) begin
            err_funds_d = 1'b1;
          end else begin
            vend_valid_d      = 1'b1;
            vend_item_d       = item_idx;
            credit_d          = credit_q - price;
            stock_d[item_idx] = stock_q[item_idx] - 1'b1;
          end
        end
        // A coin that shares its cycle with a higher-priority event is returned.
        if (coin_hit) begin
          if (bus.admin_mode || bus.cancel || item_hit || coin_multi || coin_sum[CREDIT_W])
            coin_reject_d = 1'b1;
          else
            credit_d = coin_sum[CREDIT_W-1:0];
        end
      end

      ST_CHANGE: begin
        coin_reject_d = coin_hit;
        if (accept) begin
          credit_d = pick_credit;
          if (pick_found) begin
            change_coin_d = pick_idx;
          end else begin
            change_valid_d = 1'b0;
            state_d        = ST_IDLE;
          end
        end
      end

      ST_ADMIN: begin
        coin_reject_d = coin_hit;
        if (item_hit)        stock_d[item_idx] = MAX_STOCK;
        if (bus.cancel)      credit_d = '0;
        if (!bus.admin_mode) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      // NOTE: the stock array is reset to full in a loop. It is a small bank of flops, not a RAM.
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= MAX_STOCK;
      vend_valid_q   <= 1'b0;
      vend_item_q    <= '0;
      change_valid_q <= 1'b0;
      change_coin_q  <= '0;
      coin_reject_q  <= 1'b0;
      err_sold_out_q <= 1'b0;
      err_funds_q    <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      credit_q       <= credit_d;
      stock_q        <= stock_d;
      vend_valid_q   <= vend_valid_d;
      vend_item_q    <= vend_item_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
      err_sold_out_q <= err_sold_out_d;
      err_funds_q    <= err_funds_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) bus.sold_out[i] = (stock_q[i] == '0);
  end

  assign bus.credit       = credit_q;
  assign bus.vend_valid   = vend_valid_q;
  assign bus.vend_item    = vend_item_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_coin  = change_coin_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.err_sold_out = err_sold_out_q;
  assign bus.err_funds    = err_funds_q;
  assign bus.busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_vending_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_vending_ctrl_param
// Directed bench for vending_ctrl_param with default parameters.
// Coin values, indexed 0..2: 1, 5, 10.
// Item prices, indexed 0..7: 2, 5, 12, 7, 10, 15, 20, 25.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vending_ctrl_param;
  import vending_pkg::*;

  localparam int NI = 8;
  localparam int NC = 3;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  vending_ctrl_param_if #(.NUM_ITEMS(NI), .NUM_COINS(NC), .CREDIT_W(8)) bus ();

  vending_ctrl_param dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Applies one cycle of pulse inputs and returns 1 ns after the edge that
  // sampled them. At that point the registered response is visible.
  task automatic step(input logic [NC-1:0] c, input logic [NI-1:0] s, input logic can);
    bus.coin_in  = c;
    bus.item_sel = s;
    bus.cancel   = can;
    @(posedge clk);
    #1;
    bus.coin_in  = '0;
    bus.item_sel = '0;
    bus.cancel   = 1'b0;
  endtask

  // Enter admin mode, clear the cash box, and leave.
  task automatic admin_clear();
    bus.admin_mode = 1'b1;
    step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    bus.admin_mode = 1'b0;
    step('0, '0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.coin_in = '0;
    bus.item_sel = '0;
    bus.cancel = 1'b0;
    bus.admin_mode = 1'b0;
    bus.change_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_credit", bus.credit, 0);
    check("rst_vend_valid", bus.vend_valid, 0);
    check("rst_change_valid", bus.change_valid, 0);
    check("rst_sold_out", bus.sold_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_vend_item", bus.vend_item, 0);
    check("rst_change_coin", bus.change_coin, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Coins 10, 5, 1 give 16. Item 2 (price 12) then leaves 4.
    step(3'b100, '0, 1'b0);
    check("coin10", bus.credit, 10);
    step(3'b010, '0, 1'b0);
    step(3'b001, '0, 1'b0);
    check("coin16", bus.credit, 16);
    step('0, 8'b0000_0100, 1'b0);
    check("vend2_valid", bus.vend_valid, 1);
    check("vend2_item", bus.vend_item, 2);
    check("vend2_credit", bus.credit, 4);
    check("vend2_stock", dut.stock_q[2], 14);
    step('0, '0, 1'b0);
    check("vend_pulse_clear", bus.vend_valid, 0);

    // A credit of 3 cannot buy item 1 (price 5).
    admin_clear();
    check("admin_clear", bus.credit, 0);
    repeat (3) step(3'b001, '0, 1'b0);
    check("credit3", bus.credit, 3);
    step('0, 8'b0000_0010, 1'b0);
    check("funds_err", bus.err_funds, 1);
    check("funds_no_vend", bus.vend_valid, 0);
    check("funds_credit", bus.credit, 3);

    // Drain item 0 (price 2) with 15 vends paid from 30 of credit.
    admin_clear();
    repeat (3) step(3'b100, '0, 1'b0);
    check("credit30", bus.credit, 30);
    for (int i = 0; i < 15; i++) begin
      step('0, 8'b0000_0001, 1'b0);
      check($sformatf("drain_vend%0d", i), bus.vend_valid, 1);
    end
    check("drain_credit", bus.credit, 0);
    check("sold_out0", bus.sold_out[0], 1);
    step('0, 8'b0000_0001, 1'b0);
    check("sold_out_err", bus.err_sold_out, 1);
    check("sold_out_no_funds_err", bus.err_funds, 0);
    check("sold_out_no_vend", bus.vend_valid, 0);
    bus.admin_mode = 1'b1;
    step('0, '0, 1'b0);
    check("admin_busy", bus.busy, 1);
    step(3'b001, 8'b0000_0001, 1'b0);
    check("admin_coin_reject", bus.coin_reject, 1);
    check("restock0", dut.stock_q[0], 15);
    check("restock_sold_out", bus.sold_out[0], 0);
    bus.admin_mode = 1'b0;
    step('0, '0, 1'b0);
    check("admin_exit", bus.busy, 0);

    // Saturation at the top of the credit range.
    repeat (25) step(3'b100, '0, 1'b0);
    check("credit250", bus.credit, 250);
    step(3'b100, '0, 1'b0);
    check("sat_reject", bus.coin_reject, 1);
    check("sat_credit", bus.credit, 250);
    step(3'b010, '0, 1'b0);
    check("credit255", bus.credit, 255);
    step(3'b001, '0, 1'b0);
    check("sat255_reject", bus.coin_reject, 1);
    check("sat255_credit", bus.credit, 255);
    step(3'b001, 8'b0000_0100, 1'b0);
    check("same_cycle_vend", bus.vend_valid, 1);
    check("same_cycle_reject", bus.coin_reject, 1);
    check("same_cycle_credit", bus.credit, 243);
    step(3'b011, '0, 1'b0);
    check("multi_coin_reject", bus.coin_reject, 1);
    check("multi_coin_credit", bus.credit, 243);
    step('0, 8'b0000_0110, 1'b0);
    check("multi_item_idx", bus.vend_item, 1);
    check("multi_item_credit", bus.credit, 238);

    // Greedy change return of 16: coins 10, 5, 1, with hopper stalls.
    admin_clear();
    step(3'b100, '0, 1'b0);
    step(3'b010, '0, 1'b0);
    step(3'b001, '0, 1'b0);
    step('0, '0, 1'b1);
    check("chg_valid", bus.change_valid, 1);
    check("chg_coin_a", bus.change_coin, 2);
    check("chg_busy", bus.busy, 1);
    bus.change_ready = 1'b1;
    step('0, '0, 1'b0);
    check("chg_coin_b", bus.change_coin, 1);
    check("chg_credit_b", bus.credit, 6);
    bus.change_ready = 1'b0;
    step(3'b100, 8'b0000_0001, 1'b0);
    check("chg_stall_valid", bus.change_valid, 1);
    check("chg_stall_coin", bus.change_coin, 1);
    check("chg_coin_reject", bus.coin_reject, 1);
    check("chg_stall_credit", bus.credit, 6);
    check("chg_ignore_item", bus.vend_valid, 0);
    bus.change_ready = 1'b1;
    step('0, '0, 1'b0);
    check("chg_coin_c", bus.change_coin, 0);
    check("chg_credit_c", bus.credit, 1);
    bus.change_ready = 1'b0;
    step('0, '0, 1'b0);
    check("chg_stall2_valid", bus.change_valid, 1);
    bus.change_ready = 1'b1;
    step('0, '0, 1'b0);
    bus.change_ready = 1'b0;
    check("chg_done_valid", bus.change_valid, 0);
    check("chg_done_credit", bus.credit, 0);
    check("chg_done_state", dut.state_q, ST_IDLE);
    check("chg_done_busy", bus.busy, 0);

    // Cancel below the smallest coin: credit 0 stays in IDLE.
    step('0, '0, 1'b1);
    check("cancel_empty", bus.busy, 0);

    // A reset in the middle of change return aborts it asynchronously.
    step(3'b100, '0, 1'b0);
    step(3'b100, '0, 1'b0);
    step('0, '0, 1'b1);
    check("mid_chg_valid", bus.change_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", bus.change_valid, 0);
    check("async_rst_credit", bus.credit, 0);
    check("async_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_stock2", dut.stock_q[2], 15);
    check("rst_stock1", dut.stock_q[1], 15);
    check("rst_sold_out_after", bus.sold_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
